// File: rtl/avg_sample_feeder_if.sv
// Bus bundle between the sample feeder, its upstream producer,
// the averager and the downstream result consumer.
//   in_*     : upstream sample handshake
//   start/DATAin, avg_ready/avg_w : averager side
//   res_*    : result handshake, err : sticky watchdog flag
interface avg_sample_feeder_if #(
  parameter int DW = 8,
  parameter int WW = 11
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic [DW-1:0] DATAin;
  logic          avg_ready;
  logic [WW-1:0] avg_w;
  logic [WW-1:0] res_w;
  logic [DW-1:0] res_mean;
  logic          res_valid;
  logic          res_ack;
  logic          err;

  modport master (
    input  in_data, in_valid,
    input  avg_ready, avg_w,
    input  res_ack,
    output in_ready, start, DATAin,
    output res_w, res_mean, res_valid,
    output err
  );

  modport slave (
    output in_data, in_valid,
    output avg_ready, avg_w,
    output res_ack,
    input  in_ready, start, DATAin,
    input  res_w, res_mean, res_valid,
    input  err
  );
endinterface

// File: rtl/avg_sample_feeder.sv
// Source-side controller for the averager: buffers N samples,
// pulses start, streams them out, captures the sum and holds it.
//   clk, rst : clock and synchronous active-high reset
//   bus      : master side of avg_sample_feeder_if
module avg_sample_feeder #(
  parameter int N       = 8,
  parameter int DW      = 8,
  parameter int WW      = 11,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  avg_sample_feeder_if.master bus
);
  localparam int LG = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FILL,
    START,
    STREAM,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] sbuf [N];
  logic [LG-1:0] wr_ptr;
  logic [LG-1:0] rd_ptr;
  logic [TW-1:0] wdog;
  logic [WW-1:0] res_w_q;
  logic          err_q;

  logic          take;
  logic          last_in;
  logic          last_out;
  logic          expired;

  assign take     = (state == FILL) && bus.in_valid;
  assign last_in  = wr_ptr == LG'(N - 1);
  assign last_out = rd_ptr == LG'(N - 1);
  assign expired  = wdog == TW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FILL:   if (take && last_in) state_n = START;
      START:  state_n = STREAM;
      STREAM: if (last_out) state_n = WAIT;
      WAIT: begin
        // a response on the final watchdog cycle still wins
        if (bus.avg_ready) state_n = HOLD;
        else if (expired)  state_n = FILL;
      end
      HOLD:   if (bus.res_ack) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && take) sbuf[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wdog    <= '0;
      res_w_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (take) wr_ptr <= wr_ptr + LG'(1);
      if (state == START) rd_ptr <= '0;
      else if (state == STREAM) rd_ptr <= rd_ptr + LG'(1);
      if (state == WAIT) wdog <= wdog + TW'(1);
      else               wdog <= '0;
      if (state == WAIT && bus.avg_ready)
        res_w_q <= bus.avg_w;
      if (state == WAIT && !bus.avg_ready && expired)
        err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = state == FILL;
  assign bus.start     = state == START;
  assign bus.DATAin    = (state == STREAM) ? sbuf[rd_ptr] : '0;
  assign bus.res_valid = state == HOLD;
  assign bus.res_w     = res_w_q;
  assign bus.res_mean  = res_w_q[WW-1:LG];
  assign bus.err       = err_q;
endmodule

// File: tb/tb_avg_sample_feeder.sv
// Self-checking bench for avg_sample_feeder with an averager model
// and a plain-arithmetic reference for sums and stream order.
module tb_avg_sample_feeder;
  localparam int N       = 8;
  localparam int DW      = 8;
  localparam int WW      = 11;
  localparam int TIMEOUT = 64;

  typedef logic [DW-1:0] blk_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avg_sample_feeder_if #(.DW(DW), .WW(WW)) bus ();

  avg_sample_feeder #(
    .N(N), .DW(DW), .WW(WW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  // averager model: counts start pulses, records the streamed
  // samples and answers two cycles after the last one
  int            avg_mode  = 0;
  int            start_cnt = 0;
  logic [DW-1:0] seen [$];
  int            m_phase   = 0;
  int            m_n       = 0;
  int            m_sum     = 0;
  int            m_dly     = 0;

  always @(negedge clk) begin
    bus.avg_ready = 1'b0;
    if (rst) begin
      m_phase   = 0;
      bus.avg_w = '0;
    end else if (bus.start) begin
      start_cnt++;
      m_phase = 1;
      m_n     = 0;
      m_sum   = 0;
    end else if (m_phase == 1) begin
      seen.push_back(bus.DATAin);
      m_sum += int'(bus.DATAin);
      m_n++;
      if (m_n == N) begin
        m_phase = 2;
        m_dly   = 0;
      end
    end else if (m_phase == 2) begin
      m_dly++;
      if (m_dly == 2) begin
        m_phase = 0;
        if (avg_mode == 0) begin
          bus.avg_ready = 1'b1;
          bus.avg_w     = WW'(m_sum);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  function automatic int ref_sum(input blk_t s);
    int t = 0;
    foreach (s[i]) t += int'(s[i]);
    return t;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive one block; returns in the cycle after the N-th handshake
  task automatic feed(input blk_t s, input bit gapped,
                      output int hs, output bit early);
    int idx = 0;
    int budget = 0;
    early = 1'b0;
    while (idx < N && budget < 400) begin
      if (bus.start) early = 1'b1;
      bus.in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = s[idx];
      if (bus.in_valid && bus.in_ready) idx++;
      step(1);
      budget++;
    end
    bus.in_valid = 1'b0;
    hs = idx;
  endtask

  task automatic wait_valid(output bit ok);
    int b = 0;
    while (!bus.res_valid && b < 200) begin
      step(1);
      b++;
    end
    ok = bus.res_valid;
  endtask

  task automatic rand_blk(output blk_t s);
    foreach (s[i]) s[i] = DW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.res_ack  = 1'b0;
    step(3);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.start !== 1'b0 ||
        bus.DATAin !== '0 || bus.res_valid !== 1'b0)
      $display("FAIL reset_ctrl got rdy=%b st=%b d=%h v=%b want 1 0 00 0",
               bus.in_ready, bus.start, bus.DATAin, bus.res_valid);
    else passed++;
    checks++;
    if (bus.res_w !== '0 || bus.res_mean !== '0 || bus.err !== 1'b0)
      $display("FAIL reset_res got w=%h m=%h err=%b want 0 0 0",
               bus.res_w, bus.res_mean, bus.err);
    else passed++;
    step(4);
    checks++;
    if (start_cnt !== 0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_idle got starts=%0d rdy=%b want 0 1",
               start_cnt, bus.in_ready);
    else passed++;
  endtask

  task automatic test_nominal();
    blk_t s;
    int   hs;
    bit   early;
    int   sc;
    bit   bad;
    foreach (s[i]) s[i] = (i % 2 == 0) ? 8'hAA : 8'hFF;
    seen.delete();
    sc = start_cnt;
    feed(s, 1'b0, hs, early);
    checks++;
    if (hs != N || bus.start !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL nom_start got hs=%0d st=%b rdy=%b want 8 1 0",
               hs, bus.start, bus.in_ready);
    else passed++;
    for (int k = 0; k < N; k++) begin
      step(1);
      checks++;
      if (bus.DATAin !== s[k] || bus.start !== 1'b0)
        $display("FAIL nom_stream k=%0d got d=%h st=%b want %h 0",
                 k, bus.DATAin, bus.start, s[k]);
      else passed++;
    end
    step(1);
    checks++;
    if (bus.DATAin !== '0 || bus.res_valid !== 1'b0)
      $display("FAIL nom_wait got d=%h v=%b want 00 0",
               bus.DATAin, bus.res_valid);
    else passed++;
    step(1);
    checks++;
    if (bus.res_valid !== 1'b0)
      $display("FAIL nom_early_valid got %b want 0", bus.res_valid);
    else passed++;
    step(1);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_w !== 11'h6A4 ||
        bus.res_mean !== 8'hD4)
      $display("FAIL nom_result got v=%b w=%h m=%h want 1 6a4 d4",
               bus.res_valid, bus.res_w, bus.res_mean);
    else passed++;
    checks++;
    if (start_cnt - sc != 1)
      $display("FAIL nom_start_count got %0d want 1", start_cnt - sc);
    else passed++;
    bad = seen.size() != N;
    for (int i = 0; i < N && !bad; i++)
      if (seen[i] !== s[i]) bad = 1'b1;
    checks++;
    if (bad)
      $display("FAIL nom_order got %0d samples out of order want 8 in order",
               seen.size());
    else passed++;
    bus.res_ack = 1'b1;
    step(1);
    bus.res_ack = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL nom_ack got v=%b rdy=%b want 0 1",
               bus.res_valid, bus.in_ready);
    else passed++;
  endtask

  task automatic test_full_scale();
    blk_t s;
    int   hs;
    bit   early;
    bit   ok;
    int   e;
    for (int p = 0; p < 2; p++) begin
      foreach (s[i]) s[i] = (p == 0) ? 8'hFF : 8'h00;
      e = ref_sum(s);
      feed(s, 1'b0, hs, early);
      wait_valid(ok);
      checks++;
      if (!ok || bus.res_w !== WW'(e) || bus.res_mean !== DW'(e / N))
        $display("FAIL full_scale p=%0d got ok=%b w=%0d m=%0d want %0d %0d",
                 p, ok, bus.res_w, bus.res_mean, e, e / N);
      else passed++;
      bus.res_ack = 1'b1;
      step(1);
      bus.res_ack = 1'b0;
    end
  endtask

  task automatic test_gapped();
    blk_t s;
    int   hs;
    bit   early;
    bit   ok;
    bit   bad;
    int   e;
    for (int r = 0; r < 4; r++) begin
      rand_blk(s);
      e = ref_sum(s);
      seen.delete();
      feed(s, 1'b1, hs, early);
      checks++;
      if (hs != N || early || bus.start !== 1'b1)
        $display("FAIL gap_hs r=%0d got hs=%0d early=%b st=%b want 8 0 1",
                 r, hs, early, bus.start);
      else passed++;
      wait_valid(ok);
      checks++;
      if (!ok || bus.res_w !== WW'(e) || bus.res_mean !== DW'(e / N))
        $display("FAIL gap_sum r=%0d got ok=%b w=%0d m=%0d want %0d %0d",
                 r, ok, bus.res_w, bus.res_mean, e, e / N);
      else passed++;
      bad = seen.size() != N;
      for (int i = 0; i < N && !bad; i++)
        if (seen[i] !== s[i]) bad = 1'b1;
      checks++;
      if (bad)
        $display("FAIL gap_order r=%0d got %0d samples out of order want 8",
                 r, seen.size());
      else passed++;
      bus.res_ack = 1'b1;
      step(1);
      bus.res_ack = 1'b0;
    end
  endtask

  task automatic test_back_pressure();
    blk_t s;
    int   hs;
    bit   early;
    bit   ok;
    bit   bad;
    int   e;
    rand_blk(s);
    e = ref_sum(s);
    feed(s, 1'b0, hs, early);
    wait_valid(ok);
    checks++;
    if (!ok)
      $display("FAIL bp_valid got 0 want 1");
    else passed++;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 ||
          bus.res_w !== WW'(e) || bus.res_mean !== DW'(e / N))
        $display("FAIL bp_hold c=%0d got rdy=%b v=%b w=%0d want 0 1 %0d",
                 c, bus.in_ready, bus.res_valid, bus.res_w, e);
      else passed++;
      step(1);
    end
    bus.in_valid = 1'b0;
    bus.res_ack  = 1'b1;
    step(1);
    bus.res_ack  = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("FAIL bp_resume got rdy=%b v=%b want 1 0",
               bus.in_ready, bus.res_valid);
    else passed++;
    rand_blk(s);
    e = ref_sum(s);
    seen.delete();
    feed(s, 1'b0, hs, early);
    wait_valid(ok);
    bad = seen.size() != N;
    for (int i = 0; i < N && !bad; i++)
      if (seen[i] !== s[i]) bad = 1'b1;
    checks++;
    if (!ok || bad || bus.res_w !== WW'(e))
      $display("FAIL bp_next got ok=%b order_bad=%b w=%0d want 1 0 %0d",
               ok, bad, bus.res_w, e);
    else passed++;
    bus.res_ack = 1'b1;
    step(1);
    bus.res_ack = 1'b0;
  endtask

  task automatic test_watchdog();
    blk_t s;
    int   hs;
    bit   early;
    bit   ok;
    int   e;
    avg_mode = 1;
    rand_blk(s);
    feed(s, 1'b0, hs, early);
    step(N + 1);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL wd_entry got v=%b err=%b want 0 0",
               bus.res_valid, bus.err);
    else passed++;
    step(TIMEOUT - 1);
    checks++;
    if (bus.err !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL wd_before got err=%b rdy=%b want 0 0",
               bus.err, bus.in_ready);
    else passed++;
    step(1);
    checks++;
    if (bus.err !== 1'b1 || bus.in_ready !== 1'b1)
      $display("FAIL wd_fire got err=%b rdy=%b want 1 1",
               bus.err, bus.in_ready);
    else passed++;
    avg_mode = 0;
    rand_blk(s);
    e = ref_sum(s);
    feed(s, 1'b0, hs, early);
    wait_valid(ok);
    checks++;
    if (!ok || bus.res_w !== WW'(e) || bus.err !== 1'b1)
      $display("FAIL wd_after got ok=%b w=%0d err=%b want 1 %0d 1",
               ok, bus.res_w, bus.err, e);
    else passed++;
    bus.res_ack = 1'b1;
    step(1);
    bus.res_ack = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    blk_t s;
    int   hs;
    bit   early;
    bit   ok;
    int   e;
    int   sc;
    rand_blk(s);
    feed(s, 1'b0, hs, early);
    step(4);
    checks++;
    if (bus.DATAin !== s[3])
      $display("FAIL rms_pre got d=%h want %h", bus.DATAin, s[3]);
    else passed++;
    rst = 1'b1;
    step(1);
    checks++;
    if (bus.DATAin !== '0 || bus.start !== 1'b0 ||
        bus.res_valid !== 1'b0 || bus.err !== 1'b0 ||
        bus.in_ready !== 1'b1)
      $display("FAIL rms_post got d=%h st=%b v=%b err=%b rdy=%b want 00 0 0 0 1",
               bus.DATAin, bus.start, bus.res_valid, bus.err, bus.in_ready);
    else passed++;
    rst = 1'b0;
    sc = start_cnt;
    step(12);
    checks++;
    if (start_cnt != sc || bus.res_w !== '0)
      $display("FAIL rms_quiet got starts=%0d w=%0d want 0 0",
               start_cnt - sc, bus.res_w);
    else passed++;
    rand_blk(s);
    e = ref_sum(s);
    seen.delete();
    feed(s, 1'b0, hs, early);
    wait_valid(ok);
    checks++;
    if (!ok || bus.res_w !== WW'(e) || bus.res_mean !== DW'(e / N))
      $display("FAIL rms_fresh got ok=%b w=%0d m=%0d want 1 %0d %0d",
               ok, bus.res_w, bus.res_mean, e, e / N);
    else passed++;
    bus.res_ack = 1'b1;
    step(1);
    bus.res_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_full_scale();
    test_gapped();
    test_back_pressure();
    test_watchdog();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/avg_sample_feeder.md
# avg_sample_feeder

Source-side controller for the averaging datapath (`avrage`). It collects 8-bit samples from an upstream producer over a valid/ready handshake into an N-entry buffer. Once the buffer is full, it issues a one-cycle `start` and streams the samples to the averager, one per clock. It then waits for the averager's `ready`, captures the 11-bit sum `w`, and presents sum and mean downstream until acknowledged, with a watchdog on the averager response.

## Interface
- `N`, 8: samples per block; power of two, fixed at 8 to match the averager.
- `DW`, 8: sample width.
- `WW`, 11: sum width, equal to DW + log2(N).
- `TIMEOUT`, 64: maximum cycles spent in WAIT before error.

One clock; reset is synchronous and active-high.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `in_data` in DW: upstream sample.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: feeder accepts a sample this cycle.
- `start` out 1: one-cycle start pulse to the averager.
- `DATAin` out DW: sample bus to the averager.
- `avg_ready` in 1: averager result valid.
- `avg_w` in WW: averager sum.
- `res_w` out WW: captured sum.
- `res_mean` out DW: `res_w >> log2(N)`, truncated.
- `res_valid` out 1: result available.
- `res_ack` in 1: downstream consumes the result.
- `err` out 1: sticky watchdog error.

## Operation
- States: FILL, START, STREAM, WAIT, HOLD.
- **FILL**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: `buf[wr_ptr] <= in_data`, `wr_ptr++`.
  - When the N-th sample is accepted, go to START. `wr_ptr` wraps to 0.
- **START**
  - `start` = 1 for exactly this cycle. `rd_ptr` = 0. Next state is STREAM.
- **STREAM**
  - Lasts N cycles. `DATAin` = `buf[rd_ptr]`, `rd_ptr++` each cycle.
  - After `buf[N-1]` is driven, go to WAIT.
  - The averager samples `DATAin` on the N rising edges following the start cycle.
- **WAIT**
  - Watchdog counter increments each cycle.
  - On `avg_ready` = 1: `res_w <= avg_w`, go to HOLD, counter cleared.
  - If the counter reaches TIMEOUT with no `avg_ready`: `err <= 1`, go to FILL, buffer discarded.
- **HOLD**
  - `res_valid` = 1; `res_w` and `res_mean` stable.
  - On `res_ack`: `res_valid` drops next cycle, go to FILL.
  - `res_ack` is ignored in every other state.
- `in_ready` = 0 in every state except FILL; upstream is back-pressured during START, STREAM, WAIT and HOLD.
- `DATAin` = 0 outside STREAM. `start` = 0 outside START.
- `err` is sticky until `rst` and does not block operation.
- Arithmetic: `res_mean` = `res_w[WW-1:log2 N]`, an unsigned floor; no rounding.
- `avg_ready` is only acted on in WAIT. A level already high at WAIT entry is accepted on the first WAIT cycle.

## Timing
- Reset values: state FILL, `in_ready` 1 (the cycle after reset), `start` 0, `DATAin` 0, `res_w` 0, `res_mean` 0, `res_valid` 0, `err` 0, both pointers 0, watchdog 0.
- Reset mid-operation (any state) discards the buffer and any in-flight result; no `start` is issued afterwards.
- If the N-th sample is accepted on edge t, `start` = 1 during cycle t+1.
- `DATAin` = `buf[k]` during cycle t+2+k, for k = 0..N-1.
- WAIT begins at cycle t+2+N.
- `avg_ready` seen on edge e gives `res_valid` = 1 from cycle e+1.
- `res_ack` on edge h gives `res_valid` = 0 and `in_ready` = 1 from cycle h+1.
- Best-case block turnaround is N (fill) + 1 + N + 1 (WAIT) + 1 (HOLD) cycles.
- Timeout fires on the TIMEOUT-th consecutive WAIT cycle. `err` = 1 and state FILL from the following cycle.
- `in_valid` held high with `in_ready` = 0 causes no acceptance.

## Test plan
- **Nominal block:** feed 0xAA, 0xFF alternating ×4, with an averager model that returns the sum 2 cycles after the last sample.
  - `start` pulses once for 1 cycle.
  - `DATAin` sequence is AA, FF, AA, FF, AA, FF, AA, FF on consecutive cycles.
  - `res_w` = 0x6A4 (1700), `res_mean` = 0xD4 (212).
- **Full scale:** 8 × 0xFF gives `res_w` = 2040 (0x7F8), `res_mean` = 0xFF. 8 × 0x00 gives 0 / 0.
- **Back-pressure:** hold `res_ack` = 0 for 20 cycles while upstream keeps `in_valid` = 1.
  - `in_ready` stays 0 and `res_valid` stays 1, with stable values.
  - Acking resumes FILL next cycle and the next 8 samples are accepted in order.
- **Gapped input:** toggle `in_valid` randomly during FILL. Exactly 8 handshakes occur before `start`, and buffer order matches handshake order.
- **Watchdog:** the averager model never asserts `avg_ready`. `err` = 1 exactly TIMEOUT (64) cycles after WAIT entry, then FILL. The next block completes normally with `err` still 1.
- **Reset mid-STREAM:** assert `rst` at the 4th `DATAin` cycle.
  - Next cycle: `DATAin` = 0, `start` = 0, `res_valid` = 0, `err` = 0, `in_ready` = 1.
  - A fresh 8-sample block produces the correct sum.
